regfile_access_ctrl: RTL



---
 rtl/regfile_access_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Single-port register-file initiator: two operand reads per request (5 cycles, +1 per pending write), one-deep write buffer.
// Writes drain whenever no read is issued; rspValid holds until rspReady, and reqReady/wbReady drop while busy/full.
module regfile_access_ctrl #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData1,
  output logic [31:0] rspData2,
  output logic        rspErr,
  input  logic        wbValid,
  output logic        wbReady,
  input  logic [4:0]  wbIndex,
  input  logic [31:0] wbData,
  output logic [4:0]  index,
  output logic [31:0] valueInput,
  output logic        readEnable,
  output logic        writeEnable,
  output logic        regWriteW,
  input  logic [31:0] valueOutput,
  input  logic        flagOutput
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD1  = 3'd1;
  localparam logic [2:0] S_W1   = 3'd2;
  localparam logic [2:0] S_RD2  = 3'd3;
  localparam logic [2:0] S_W2   = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  // Watchdog value seen in the last wait cycle, so a wait state lasts exactly TIMEOUT cycles.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        err;
  logic [7:0]  wdog;

  logic        wb_pend;
  logic [4:0]  wb_idx;
  logic [31:0] wb_dat;

  logic        in_rd;
  logic [4:0]  rd_src;
  logic        issue_rd;
  logic        drain;
  logic        wb_acc;
  logic        wd_expired;

  assign in_rd      = (state == S_RD1) || (state == S_RD2);
  assign rd_src     = (state == S_RD2) ? src2 : src1;
  assign issue_rd   = in_rd && (rd_src != 5'd0) && !wb_pend;
  assign drain      = wb_pend && !issue_rd;
  assign wb_acc     = wbValid && !wb_pend;
  assign wd_expired = (wdog >= WD_LAST);

  assign reqReady = (state == S_IDLE);
  assign rspValid = (state == S_RESP);
  assign wbReady  = !wb_pend;
  assign rspData1 = data1;
  assign rspData2 = data2;
  assign rspErr   = err;

  always_comb begin
    readEnable  = issue_rd;
    writeEnable = drain;
    regWriteW   = drain;
    index       = 5'd0;
    valueInput  = 32'd0;
    if (issue_rd) begin
      index = rd_src;
    end else if (drain) begin
      index      = wb_idx;
      valueInput = wb_dat;
    end
  end

  // A write accepted on an edge drains no earlier than the following cycle,
  // so it always lands after any read issued alongside its acceptance.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wb_pend <= 1'b0;
      wb_idx  <= 5'd0;
      wb_dat  <= 32'd0;
    end else if (wb_acc) begin
      if (wbIndex != 5'd0) begin
        wb_pend <= 1'b1;
        wb_idx  <= wbIndex;
        wb_dat  <= wbData;
      end
    end else if (drain) begin
      wb_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
      src1  <= 5'd0;
      src2  <= 5'd0;
      data1 <= 32'd0;
      data2 <= 32'd0;
      err   <= 1'b0;
      wdog  <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (reqValid) begin
            src1  <= rs1;
            src2  <= rs2;
            data1 <= 32'd0;
            data2 <= 32'd0;
            err   <= 1'b0;
            state <= S_RD1;
          end
        end
        S_RD1: begin
          if (src1 == 5'd0) begin
            data1 <= 32'd0;
            state <= S_RD2;
          end else if (!wb_pend) begin
            wdog  <= 8'd0;
            state <= S_W1;
          end
        end
        S_W1: begin
          if (flagOutput) begin
            data1 <= valueOutput;
            state <= S_RD2;
          end else if (wd_expired) begin
            data1 <= 32'd0;
            err   <= 1'b1;
            state <= S_RD2;
          end else if (wdog != 8'hFF) begin
            wdog <= wdog + 8'd1;
          end
        end
        S_RD2: begin
          if (src2 == 5'd0) begin
            data2 <= 32'd0;
            state <= S_RESP;
          end else if (!wb_pend) begin
            wdog  <= 8'd0;
            state <= S_W2;
          end
        end
        S_W2: begin
          if (flagOutput) begin
            data2 <= valueOutput;
            state <= S_RESP;
          end else if (wd_expired) begin
            data2 <= 32'd0;
            err   <= 1'b1;
            state <= S_RESP;
          end else if (wdog != 8'hFF) begin
            wdog <= wdog + 8'd1;
          end
        end
        S_RESP: begin
          if (rspReady) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
